// File: rtl/boa_mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Grants are held until the memory answers ready. The port is muxed combinationally, so the arbiter adds no latency.
module boa_mem_arbiter #(
    parameter bit RR = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_re,
    input  logic [29:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_re,
    input  logic [3:0]  d_we,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_re,
    output logic [3:0]  m_we,
    output logic [29:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata,
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_MEM  = 2'b10
    } owner_e;

    owner_e owner_q, owner_d;
    owner_e last_q, last_d;
    owner_e sel;
    logic   i_req, d_req;

    assign i_req = i_re;
    assign d_req = d_re | (|d_we);

    // An owner whose request has dropped is treated as released, so the
    // other requester can take the port in the same cycle as the abort.
    always_comb begin
        sel = OWN_NONE;
        if (rst) begin
            sel = OWN_NONE;
        end else if (owner_q == OWN_IF && i_req) begin
            sel = OWN_IF;
        end else if (owner_q == OWN_MEM && d_req) begin
            sel = OWN_MEM;
        end else if (i_req && d_req) begin
            sel = (RR && last_q == OWN_MEM) ? OWN_IF : OWN_MEM;
        end else if (i_req) begin
            sel = OWN_IF;
        end else if (d_req) begin
            sel = OWN_MEM;
        end
    end

    always_comb begin
        m_re    = 1'b0;
        m_we    = 4'b0000;
        m_addr  = 30'd0;
        m_wdata = 32'd0;
        unique case (sel)
            OWN_IF: begin
                m_re   = i_re;
                m_addr = i_addr;
            end
            OWN_MEM: begin
                m_re    = d_re;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: ;
        endcase
    end

    assign i_ready = (sel == OWN_IF)  & m_ready;
    assign d_ready = (sel == OWN_MEM) & m_ready;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign gnt     = sel;

    always_comb begin
        owner_d = OWN_NONE;
        last_d  = last_q;
        if (sel != OWN_NONE) begin
            if (m_ready) begin
                last_d = sel;
            end else begin
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            last_q  <= OWN_MEM;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

endmodule
